// File: rtl/pi_pkg.sv
// Shared constants and types for the pi digit lookup arbiter.
package pi_pkg;

  localparam int PI_IDX_W = 24;
  localparam int DIGIT_W  = 4;
  localparam int PI_LAT   = 2;
  localparam int PI_N     = 4;
  localparam int PI_ID_W  = $clog2(PI_N);

  // Tag record carried alongside each in-flight lookup (default widths).
  typedef struct packed {
    logic                valid;
    logic [PI_ID_W-1:0]  id;
    logic [PI_IDX_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  // Scan requesters starting at the pointer and take the first one found.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pi_digit_arbiter.sv
// Shares one pipelined pi digit lookup between N requesters and routes
// each returned digit back to the requester that issued its index.
module pi_digit_arbiter
  import pi_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = PI_IDX_W,
  parameter int LAT   = PI_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*IDX_W-1:0]   req_index,
  output logic [N-1:0]         req_ready,
  output logic [IDX_W-1:0]     lu_index,
  input  logic [DIGIT_W-1:0]   lu_digit,
  output logic [N-1:0]         rsp_valid,
  output logic [IDX_W-1:0]     rsp_index,
  output logic [DIGIT_W-1:0]   rsp_digit
);

  localparam int          ID_W = $clog2(N);
  localparam int unsigned LAST = LAT;

  // Same layout as pi_pkg::tag_t, sized for this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [IDX_W-1:0] index;
  } inst_tag_t;

  logic [ID_W-1:0]  ptr;
  logic [N-1:0]     grant;
  logic [ID_W-1:0]  grant_id;
  logic [IDX_W-1:0] sel_index;
  logic             accept;
  inst_tag_t        tags [LAT+1];

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant is suppressed during reset so nothing is accepted that cycle.
  always_comb begin
    req_ready = rst ? '0 : grant;
    accept    = |(req_ready & req_valid);
    sel_index = req_index[grant_id*IDX_W +: IDX_W];
  end

  // Issue lookups, advance the pointer, shift tags and register responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_index  <= '0;
      ptr       <= '0;
      rsp_valid <= '0;
      rsp_index <= '0;
      rsp_digit <= '0;
      for (int unsigned s = 0; s <= LAST; s++) begin
        tags[s] <= '0;
      end
    end else begin
      if (accept) begin
        lu_index <= sel_index;
        ptr      <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
      end
      tags[0] <= '{valid: accept, id: grant_id, index: sel_index};
      for (int unsigned s = 1; s <= LAST; s++) begin
        tags[s] <= tags[s-1];
      end
      if (tags[LAST].valid) begin
        rsp_valid <= N'(1) << tags[LAST].id;
        rsp_index <= tags[LAST].index;
        rsp_digit <= lu_digit;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule
